// File: rtl/round_pkg.sv
// Shared constants and helpers for the round-robin rounding arbiter.
// ROUND_ARB_SAT_EN (optional) makes round_unit clamp positive overflow instead of wrapping.
package round_pkg;

    localparam int IN_W_DEF   = 8;
    localparam int FRAC_W_DEF = 4;
    localparam int OUT_W_DEF  = IN_W_DEF - FRAC_W_DEF;

    function automatic int round_half(input int frac_w);
        return 1 << (frac_w - 1);
    endfunction

    localparam int ROUND_HALF = 1 << (FRAC_W_DEF - 1);

    // Never returns less than 1 so a two-requester build still gets a real ID bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << w) < n) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/round_unit.sv
// Combinational signed Q(IN_W-FRAC_W, FRAC_W) to integer rounding, half-up toward +inf.
// ROUND_ARB_SAT_EN: when defined, overflowing results clamp to the largest positive value.
module round_unit
    import round_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic [IN_W-1:0]  q_i,
    output logic [OUT_W-1:0] y_o,
    output logic             ovf_o
);

    localparam logic [IN_W:0]         HALF    = (IN_W+1)'(round_half(FRAC_W));
    localparam logic signed [OUT_W:0] MAX_POS = (OUT_W+1)'((1 << (OUT_W - 1)) - 1);

    logic [IN_W:0]         sum;
    logic signed [OUT_W:0] r;
    logic                  unusedFracBits;

    // Only the carry out of the fraction matters; the low bits are discarded by design.
    always_comb begin
        sum   = {q_i[IN_W-1], q_i} + HALF;
        r     = $signed(sum[IN_W:FRAC_W]);
        ovf_o = (r > MAX_POS);
`ifdef ROUND_ARB_SAT_EN
        y_o   = ovf_o ? MAX_POS[OUT_W-1:0] : r[OUT_W-1:0];
`else
        y_o   = r[OUT_W-1:0];
`endif
    end

    assign unusedFracBits = ^sum[FRAC_W-1:0];

endmodule

// File: rtl/round_arbiter.sv
// Round-robin arbiter sharing one rounding unit among N_REQ sample producers.
// ROUND_ARB_SAT_EN (optional, passed through to round_unit) selects saturating overflow.
module round_arbiter
    import round_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int IN_W   = IN_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int CNT_W  = 8,
    localparam int ID_W  = clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*IN_W-1:0] req_data,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  out_valid,
    output logic [OUT_W-1:0]      out_data,
    output logic [ID_W-1:0]       out_id,
    input  logic                  out_ready,
    output logic                  ovf,
    output logic [CNT_W-1:0]      ovf_count,
    output logic                  busy
);

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             outValid_q, outValid_d;
    logic [OUT_W-1:0] outData_q, outData_d;
    logic [ID_W-1:0]  outId_q, outId_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] ovfCount_q, ovfCount_d;

    logic             slotFree;
    logic             grantFound;
    logic             grant;
    logic [ID_W-1:0]  grantIdx;
    logic [IN_W-1:0]  grantData;
    logic [OUT_W-1:0] unitY;
    logic             unitOvf;
    int               cand;

    // First valid requester at or above the pointer, wrapping modulo N_REQ.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        cand       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(ptr_q) + k) % N_REQ;
            if (!grantFound && req_valid[cand]) begin
                grantFound = 1'b1;
                grantIdx   = ID_W'(cand);
            end
        end
    end

    assign slotFree = !outValid_q || out_ready;
    assign grant    = grantFound && slotFree && !rst;

    always_comb begin
        req_ready = '0;
        grantData = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = grant && (grantIdx == ID_W'(i));
            if (grantIdx == ID_W'(i)) begin
                grantData = req_data[i*IN_W +: IN_W];
            end
        end
    end

    round_unit #(
        .IN_W   (IN_W),
        .FRAC_W (FRAC_W),
        .OUT_W  (OUT_W)
    ) u_round (
        .q_i   (grantData),
        .y_o   (unitY),
        .ovf_o (unitOvf)
    );

    always_comb begin
        ptr_d      = ptr_q;
        outValid_d = outValid_q;
        outData_d  = outData_q;
        outId_d    = outId_q;
        ovf_d      = ovf_q;
        ovfCount_d = ovfCount_q;
        if (grant) begin
            outValid_d = 1'b1;
            outData_d  = unitY;
            outId_d    = grantIdx;
            ovf_d      = unitOvf;
            ptr_d      = (grantIdx == ID_W'(N_REQ - 1)) ? '0 : grantIdx + ID_W'(1);
            if (unitOvf && (ovfCount_q != '1)) begin
                ovfCount_d = ovfCount_q + CNT_W'(1);
            end
        end else if (slotFree) begin
            outValid_d = 1'b0;
            ovf_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outId_q    <= '0;
            ovf_q      <= 1'b0;
            ovfCount_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outId_q    <= outId_d;
            ovf_q      <= ovf_d;
            ovfCount_q <= ovfCount_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_id    = outId_q;
    assign ovf       = ovf_q;
    assign ovf_count = ovfCount_q;
    assign busy      = outValid_q || (|req_valid);

endmodule

// File: tb/tb_round_arbiter.sv
// Self-checking bench for round_arbiter: an integer-level reference model checked every cycle
// plus directed scenarios with hand-computed expectations. Honours ROUND_ARB_SAT_EN.
module tb_round_arbiter;

    localparam int N_REQ = 4;
    localparam int IN_W  = 8;
    localparam int OUT_W = 4;
    localparam int CNT_W = 8;
    localparam int ID_W  = 2;
`ifdef ROUND_ARB_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [N_REQ-1:0]      reqValid = '0;
    logic [N_REQ*IN_W-1:0] reqData = '0;
    logic                  outReady = 1'b1;
    logic [N_REQ-1:0]      reqReady;
    logic                  outValid;
    logic [OUT_W-1:0]      outData;
    logic [ID_W-1:0]       outId;
    logic                  ovf;
    logic [CNT_W-1:0]      ovfCount;
    logic                  busy;

    int assertCount = 0;
    int failCount   = 0;

    round_arbiter #(
        .N_REQ (N_REQ),
        .IN_W  (IN_W),
        .FRAC_W(4),
        .OUT_W (OUT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (reqValid),
        .req_data  (reqData),
        .req_ready (reqReady),
        .out_valid (outValid),
        .out_data  (outData),
        .out_id    (outId),
        .out_ready (outReady),
        .ovf       (ovf),
        .ovf_count (ovfCount),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Rounding from the arithmetic definition: floor((v + 8) / 16) on plain integers.
    function automatic int modelRound(input logic [7:0] q, output bit ov);
        int v;
        int s;
        int r;
        v = int'($signed(q));
        s = v + 8;
        r = (s >= 0) ? (s / 16) : -((-s + 15) / 16);
        ov = (r > 7);
        if (ov && SAT_EN) return 7;
        return r & 15;
    endfunction

    // Reference model, checked against the DUT on every falling edge.
    initial begin
        bit armed;
        bit mValid;
        bit mOvf;
        bit slotFree;
        bit found;
        bit ov;
        int mPtr;
        int mId;
        int mCnt;
        int mData;
        int win;
        int expReady;
        armed = 0; mValid = 0; mOvf = 0; mPtr = 0; mId = 0; mCnt = 0; mData = 0;
        forever begin
            @(negedge clk);
            slotFree = !mValid || outReady;
            found = 0;
            win = 0;
            for (int k = 0; k < N_REQ; k++) begin
                int j;
                j = (mPtr + k) % N_REQ;
                if (!found && reqValid[j]) begin
                    found = 1;
                    win = j;
                end
            end
            expReady = (!rst && slotFree && found) ? (1 << win) : 0;
            if (armed) begin
                checkOutput("cmp req_ready", int'(reqReady), expReady);
                checkOutput("cmp out_valid", int'(outValid), int'(mValid));
                if (mValid) begin
                    checkOutput("cmp out_data", int'(outData), mData);
                    checkOutput("cmp out_id", int'(outId), mId);
                end
                checkOutput("cmp ovf", int'(ovf), int'(mValid && mOvf));
                checkOutput("cmp ovf_count", int'(ovfCount), mCnt);
                checkOutput("cmp busy", int'(busy), int'(mValid || (reqValid != 0)));
            end
            if (rst) begin
                mValid = 0; mOvf = 0; mData = 0; mId = 0; mCnt = 0; mPtr = 0;
                armed = 1;
            end else if (expReady != 0) begin
                mData  = modelRound(reqData[win*IN_W +: IN_W], ov);
                mValid = 1;
                mId    = win;
                mOvf   = ov;
                mPtr   = (win + 1) % N_REQ;
                if (ov && mCnt < 255) mCnt++;
            end else if (slotFree) begin
                mValid = 0;
            end
        end
    end

    task automatic applyStimulus(input logic [N_REQ-1:0] valid, input logic [N_REQ*IN_W-1:0] data);
        reqValid = valid;
        reqData  = data;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        applyStimulus('0, '0);
        outReady = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Presents one sample and returns #1 after the edge that accepted it.
    task automatic sendOne(input int idx, input logic [7:0] data);
        bit got;
        got = 0;
        applyStimulus(N_REQ'(1 << idx), (N_REQ*IN_W)'(data) << (idx * IN_W));
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = reqReady[idx];
            @(posedge clk);
            #1;
        end
        if (!got) checkOutput("sendOne timeout", 0, 1);
        applyStimulus('0, '0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] ovfVec [3];
        int         ovfExp [3];
        int         ovfFlag [3];
        ovfVec[0] = 8'h7F; ovfExp[0] = SAT_EN ? 7 : 8; ovfFlag[0] = 1;
        ovfVec[1] = 8'h78; ovfExp[1] = SAT_EN ? 7 : 8; ovfFlag[1] = 1;
        ovfVec[2] = 8'h80; ovfExp[2] = 8;              ovfFlag[2] = 0;

        $display("[TB] reset state");
        resetDut();
        checkOutput("reset out_valid", int'(outValid), 0);
        checkOutput("reset out_data", int'(outData), 0);
        checkOutput("reset out_id", int'(outId), 0);
        checkOutput("reset ovf_count", int'(ovfCount), 0);

        $display("[TB] single requester rounding");
        sendOne(0, 8'h18);
        checkOutput("t1 0x18 valid", int'(outValid), 1);
        checkOutput("t1 0x18 data", int'(outData), 2);
        checkOutput("t1 0x18 id", int'(outId), 0);
        sendOne(0, 8'h17);
        checkOutput("t1 0x17 data", int'(outData), 1);
        sendOne(0, 8'hE8);
        checkOutput("t1 0xE8 data", int'(outData), 4'hF);
        sendOne(0, 8'hF8);
        checkOutput("t1 0xF8 data", int'(outData), 0);
        checkOutput("t1 0xF8 id", int'(outId), 0);

        $display("[TB] four requesters rotating");
        resetDut();
        applyStimulus(4'hF, 32'h3020_1000);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("t2 id cycle %0d", c), int'(outId), c % 4);
            checkOutput($sformatf("t2 data cycle %0d", c), int'(outData), c % 4);
        end
        applyStimulus('0, '0);

        $display("[TB] back-pressure stall");
        resetDut();
        applyStimulus(4'b1010, 32'h3000_2000);
        @(posedge clk);
        #1;
        checkOutput("t3 first id", int'(outId), 1);
        checkOutput("t3 first data", int'(outData), 2);
        outReady = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("t3 stall req_ready", int'(reqReady), 0);
            @(posedge clk);
            #1;
            checkOutput("t3 stall valid", int'(outValid), 1);
            checkOutput("t3 stall id", int'(outId), 1);
            checkOutput("t3 stall data", int'(outData), 2);
        end
        outReady = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t3 release id", int'(outId), 3);
        checkOutput("t3 release data", int'(outData), 3);
        applyStimulus('0, '0);

        $display("[TB] overflow on requester 2");
        resetDut();
        for (int v = 0; v < 3; v++) begin
            sendOne(2, ovfVec[v]);
            checkOutput($sformatf("t4 data %0h", ovfVec[v]), int'(outData), ovfExp[v]);
            checkOutput($sformatf("t4 ovf %0h", ovfVec[v]), int'(ovf), ovfFlag[v]);
            checkOutput($sformatf("t4 id %0h", ovfVec[v]), int'(outId), 2);
        end
        checkOutput("t4 ovf_count", int'(ovfCount), 2);

        $display("[TB] overflow counter saturation");
        resetDut();
        applyStimulus(4'b0001, 32'h0000_007F);
        repeat (254) @(posedge clk);
        #1;
        checkOutput("t5 count 254", int'(ovfCount), 254);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("t5 count sat", int'(ovfCount), 255);
        applyStimulus('0, '0);

        $display("[TB] reset mid-operation");
        resetDut();
        applyStimulus(4'hF, 32'h7F7F_7F7F);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t6 pre id", int'(outId), 1);
        checkOutput("t6 pre count", int'(ovfCount), 2);
        rst = 1'b1;
        #1;
        checkOutput("t6 rst req_ready", int'(reqReady), 0);
        @(posedge clk);
        #1;
        checkOutput("t6 rst out_valid", int'(outValid), 0);
        checkOutput("t6 rst ovf_count", int'(ovfCount), 0);
        rst = 1'b0;
        #1;
        checkOutput("t6 post req_ready", int'(reqReady), 1);
        @(posedge clk);
        #1;
        checkOutput("t6 post id", int'(outId), 0);
        checkOutput("t6 post valid", int'(outValid), 1);
        applyStimulus('0, '0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("idle out_valid", int'(outValid), 0);
        checkOutput("idle busy", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
